// File: rtl/red_pitaya_hk_gen2_if.sv
// System-bus slave port shared by the housekeeping block and its neighbours.
// The master drives address, data and strobes; the slave returns data, ack and err.
interface red_pitaya_hk_gen2_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_hk_gen2.sv
// Housekeeping block: design ID, FPGA DNA readout (restartable FSM), LEDs,
// digital_loop flag and the bidirectional expansion connector with synchronised
// inputs and sticky rising-edge flags (write-1-to-clear).
// Optional feature: define HK_HEARTBEAT_EN to add a free-running heartbeat counter
// that can drive the top LED (enable bit at 0x38).
module red_pitaya_hk_gen2 #(
  parameter int          DWL     = 8,
  parameter int          DWE     = 8,
  parameter logic [56:0] DNA     = 57'h0823456789ABCDE,
  parameter logic [31:0] ID_VAL  = 32'h0000_0002,
  parameter int          DNA_DIV = 4,
  parameter int          HB_BITS = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [DWL-1:0]        led_o,
  output logic                  digital_loop,
  input  logic [DWE-1:0]        exp_p_dat_i,
  output logic [DWE-1:0]        exp_p_dat_o,
  output logic [DWE-1:0]        exp_p_dir_o,
  input  logic [DWE-1:0]        exp_n_dat_i,
  output logic [DWE-1:0]        exp_n_dat_o,
  output logic [DWE-1:0]        exp_n_dir_o,
  red_pitaya_hk_gen2_if.slave   bus
);

  localparam int DIV_W = (DNA_DIV > 2) ? $clog2(DNA_DIV) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_DONE} dna_state_t;

  dna_state_t        dna_state;
  logic              dna_clk;
  logic              dna_read;
  logic              dna_shift;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [56:0]       dna_sr;
  logic [56:0]       dna_value;
  logic              dna_tick;
  logic              dna_rise;
  logic              dna_fall;
  logic              dna_restart;

  logic [DWL-1:0]    led_reg;
  logic [DWE-1:0]    p_sync1, p_sync2, p_sync3, p_flag, p_edge, p_clr;
  logic [DWE-1:0]    n_sync1, n_sync2, n_sync3, n_flag, n_edge, n_clr;
  logic [19:0]       addr;
  logic [31:0]       read_mux;
  logic [31:0]       rdata;
  logic              ack;
  logic              unused_bits;

  assign addr        = bus.sys_addr[19:0];
  assign unused_bits = ^{bus.sys_sel, bus.sys_addr[31:20], bus.sys_wdata};

  assign dna_tick    = (div_cnt == DIV_W'(DNA_DIV - 1)) && (dna_state != ST_DONE);
  assign dna_rise    = dna_tick && !dna_clk;
  assign dna_fall    = dna_tick && dna_clk;
  assign dna_restart = bus.sys_wen && (addr == 20'h00034) && bus.sys_wdata[0];

  // DNA readout FSM; dna_sr stands in for the DNA_PORT shift register (MSB = dout)
  always_ff @(posedge clk_i) begin
    if (rst_i || dna_restart) begin
      dna_state <= ST_LOAD;
      dna_clk   <= 1'b0;
      dna_read  <= 1'b1;
      dna_shift <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      dna_value <= '0;
      if (rst_i) dna_sr <= '0;
    end else begin
      if (dna_state == ST_DONE) begin
        div_cnt <= '0;
        dna_clk <= 1'b0;
      end else if (dna_tick) begin
        div_cnt <= '0;
        dna_clk <= ~dna_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (dna_rise && dna_read) dna_sr <= DNA;
      else if (dna_rise && dna_shift) dna_sr <= {dna_sr[55:0], 1'b0};

      case (dna_state)
        ST_LOAD: begin
          if (dna_fall) begin
            dna_state <= ST_SHIFT;
            dna_read  <= 1'b0;
            dna_shift <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (dna_rise) begin
            dna_value <= {dna_value[55:0], dna_sr[56]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 6'd56) begin
              dna_state <= ST_DONE;
              dna_shift <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Three-stage pad capture: two synchroniser stages plus one for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {p_sync1, p_sync2, p_sync3} <= '0;
      {n_sync1, n_sync2, n_sync3} <= '0;
    end else begin
      p_sync1 <= exp_p_dat_i;
      p_sync2 <= p_sync1;
      p_sync3 <= p_sync2;
      n_sync1 <= exp_n_dat_i;
      n_sync2 <= n_sync1;
      n_sync3 <= n_sync2;
    end
  end

  assign p_edge = p_sync2 & ~p_sync3;
  assign n_edge = n_sync2 & ~n_sync3;
  assign p_clr  = (bus.sys_wen && addr == 20'h00028) ? bus.sys_wdata[DWE-1:0] : '0;
  assign n_clr  = (bus.sys_wen && addr == 20'h0002C) ? bus.sys_wdata[DWE-1:0] : '0;

  // Sticky edge flags; a new edge beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_flag <= '0;
      n_flag <= '0;
    end else begin
      p_flag <= (p_flag & ~p_clr) | p_edge;
      n_flag <= (n_flag & ~n_clr) | n_edge;
    end
  end

`ifdef HK_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_cnt;
  logic               hb_en;

  // Free-running heartbeat counter
  always_ff @(posedge clk_i) begin
    if (rst_i) hb_cnt <= '0;
    else       hb_cnt <= hb_cnt + 1'b1;
  end

  // Heartbeat enable register at 0x38
  always_ff @(posedge clk_i) begin
    if (rst_i)                               hb_en <= 1'b0;
    else if (bus.sys_wen && addr == 20'h00038) hb_en <= bus.sys_wdata[0];
  end

  // Top LED follows the heartbeat when enabled
  always_comb begin
    led_o = led_reg;
    if (hb_en) led_o[DWL-1] = hb_cnt[HB_BITS-1];
  end
`else
  localparam int unused_hb_bits = HB_BITS;

  assign led_o = led_reg;
`endif

  // Software-writable control registers; upper write bits are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digital_loop <= 1'b0;
      exp_p_dir_o  <= '0;
      exp_n_dir_o  <= '0;
      exp_p_dat_o  <= '0;
      exp_n_dat_o  <= '0;
      led_reg      <= '0;
    end else if (bus.sys_wen) begin
      case (addr)
        20'h0000C: digital_loop <= bus.sys_wdata[0];
        20'h00010: exp_p_dir_o  <= bus.sys_wdata[DWE-1:0];
        20'h00014: exp_n_dir_o  <= bus.sys_wdata[DWE-1:0];
        20'h00018: exp_p_dat_o  <= bus.sys_wdata[DWE-1:0];
        20'h0001C: exp_n_dat_o  <= bus.sys_wdata[DWE-1:0];
        20'h00030: led_reg      <= bus.sys_wdata[DWL-1:0];
        default: ;
      endcase
    end
  end

  // Read multiplexer with zero extension of narrow fields
  always_comb begin
    read_mux = '0;
    case (addr)
      20'h00000: read_mux = ID_VAL;
      20'h00004: read_mux = dna_value[31:0];
      20'h00008: read_mux[24:0] = dna_value[56:32];
      20'h0000C: read_mux[0] = digital_loop;
      20'h00010: read_mux[DWE-1:0] = exp_p_dir_o;
      20'h00014: read_mux[DWE-1:0] = exp_n_dir_o;
      20'h00018: read_mux[DWE-1:0] = exp_p_dat_o;
      20'h0001C: read_mux[DWE-1:0] = exp_n_dat_o;
      20'h00020: read_mux[DWE-1:0] = p_sync2;
      20'h00024: read_mux[DWE-1:0] = n_sync2;
      20'h00028: read_mux[DWE-1:0] = p_flag;
      20'h0002C: read_mux[DWE-1:0] = n_flag;
      20'h00030: read_mux[DWL-1:0] = led_reg;
      20'h00034: read_mux[1:0] = {dna_state != ST_DONE, dna_state == ST_DONE};
`ifdef HK_HEARTBEAT_EN
      20'h00038: read_mux[0] = hb_en;
`endif
      default: read_mux = '0;
    endcase
  end

  // Registered bus response: ack one cycle after any strobe, data alongside it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= bus.sys_wen | bus.sys_ren;
      rdata <= bus.sys_ren ? read_mux : 32'h0;
    end
  end

  assign bus.sys_ack   = ack;
  assign bus.sys_rdata = rdata;
  assign bus.sys_err   = 1'b0;

endmodule
